// File: rtl/overflow_trap_unit.sv
// Registered add/subtract unit with signed-overflow trap, one-deep pending exception and stats.
// Optional saturating trap counter is built when OVF_TRAP_COUNTER_EN is defined.
module overflow_trap_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_in_valid,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic                 i_sub,
    input  logic                 i_signed_mode,
    input  logic [PC_WIDTH-1:0]  i_pc,
    output logic                 o_result_valid,
    output logic [WIDTH-1:0]     o_result,
    output logic                 o_carry,
    output logic                 o_overflow,
    output logic                 o_commit,
    output logic                 o_exc_req,
    output logic [PC_WIDTH-1:0]  o_exc_pc,
    input  logic                 i_exc_ack,
    output logic                 o_exc_lost,
    input  logic                 i_clr_stats,
    output logic [CNT_WIDTH-1:0] o_ovf_count
);

    typedef enum logic {StIdle, StPending} state_e;

    logic [WIDTH-1:0]    w_b_x;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH-1:0]    w_sum_low;
    logic                w_c_msb;
    logic                w_c_out;
    logic                w_overflow;
    logic                w_carry;
    logic                w_trap;

    logic                r_result_valid;
    logic [WIDTH-1:0]    r_result;
    logic                r_carry;
    logic                r_overflow;
    logic                r_signed;

    state_e              r_state, w_state_d;
    logic [PC_WIDTH-1:0] r_exc_pc, w_exc_pc_d;
    logic                r_exc_lost, w_exc_lost_d;
    logic                w_lost_set;

    // Low sum excludes the MSB so its top bit is the carry into bit WIDTH-1.
    assign w_b_x      = i_b ^ {WIDTH{i_sub}};
    assign w_sum      = {1'b0, i_a} + {1'b0, w_b_x} + (WIDTH+1)'(i_sub);
    assign w_sum_low  = {1'b0, i_a[WIDTH-2:0]} + {1'b0, w_b_x[WIDTH-2:0]} + WIDTH'(i_sub);
    assign w_c_msb    = w_sum_low[WIDTH-1];
    assign w_c_out    = w_sum[WIDTH];
    assign w_overflow = w_c_msb ^ w_c_out;
    assign w_carry    = w_c_out ^ i_sub;
    assign w_trap     = i_in_valid & i_signed_mode & w_overflow;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_result_valid <= 1'b0;
            r_result       <= '0;
            r_carry        <= 1'b0;
            r_overflow     <= 1'b0;
            r_signed       <= 1'b0;
        end else begin
            r_result_valid <= i_in_valid;
            if (i_in_valid) begin
                r_result   <= w_sum[WIDTH-1:0];
                r_carry    <= w_carry;
                r_overflow <= w_overflow;
                r_signed   <= i_signed_mode;
            end
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_exc_pc_d = r_exc_pc;
        w_lost_set = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_trap) begin
                    w_state_d  = StPending;
                    w_exc_pc_d = i_pc;
                end
            end
            StPending: begin
                if (i_exc_ack) begin
                    if (w_trap) begin
                        w_exc_pc_d = i_pc;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else if (w_trap) begin
                    w_lost_set = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Clear wins over a same-cycle sticky set.
    always_comb begin
        w_exc_lost_d = r_exc_lost;
        if (i_clr_stats) begin
            w_exc_lost_d = 1'b0;
        end else if (w_lost_set) begin
            w_exc_lost_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_exc_pc   <= '0;
            r_exc_lost <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_exc_pc   <= w_exc_pc_d;
            r_exc_lost <= w_exc_lost_d;
        end
    end

`ifdef OVF_TRAP_COUNTER_EN
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_clr_stats) begin
            w_cnt_d = w_trap ? CNT_WIDTH'(1) : '0;
        end else if (w_trap && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            w_cnt_d = r_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign o_ovf_count = r_cnt;
`else
    assign o_ovf_count = '0;
`endif

    assign o_result_valid = r_result_valid;
    assign o_result       = r_result;
    assign o_carry        = r_carry;
    assign o_overflow     = r_overflow;
    assign o_commit       = r_result_valid & ~(r_signed & r_overflow);
    assign o_exc_req      = (r_state == StPending);
    assign o_exc_pc       = r_exc_pc;
    assign o_exc_lost     = r_exc_lost;

endmodule

// File: tb/tb_overflow_trap_unit.sv
// Table-driven bench for overflow_trap_unit plus a hand-written async-reset sequence.
module tb_overflow_trap_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned PW = 32;
    localparam int unsigned CW = 2;

    logic          clk, reset, in_valid, sub, signed_mode, exc_ack, clr_stats;
    logic [W-1:0]  a, b;
    logic [PW-1:0] pc;
    logic          result_valid, carry, overflow, commit, exc_req, exc_lost;
    logic [W-1:0]  result;
    logic [PW-1:0] exc_pc;
    logic [CW-1:0] ovf_count;

    overflow_trap_unit #(.WIDTH(W), .PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_in_valid     (in_valid),
        .i_a            (a),
        .i_b            (b),
        .i_sub          (sub),
        .i_signed_mode  (signed_mode),
        .i_pc           (pc),
        .o_result_valid (result_valid),
        .o_result       (result),
        .o_carry        (carry),
        .o_overflow     (overflow),
        .o_commit       (commit),
        .o_exc_req      (exc_req),
        .o_exc_pc       (exc_pc),
        .i_exc_ack      (exc_ack),
        .o_exc_lost     (exc_lost),
        .i_clr_stats    (clr_stats),
        .o_ovf_count    (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        sm;
        logic [31:0] pc;
        logic        ack;
        logic        clr;
        logic        e_rv;
        logic [31:0] e_res;
        logic        e_c;
        logic        e_o;
        logic        e_cm;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_lost;
        logic [1:0]  e_cnt;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cur    = 0;

    function automatic logic [1:0] exp_cnt(input logic [1:0] c);
`ifdef OVF_TRAP_COUNTER_EN
        return c;
`else
        return 2'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %h, expected %h", name, cur, act, exp);
        end
    endtask

    task automatic chk_all(input vec_t e);
        chk("result_valid", 32'(result_valid), 32'(e.e_rv));
        chk("result", result, e.e_res);
        chk("carry", 32'(carry), 32'(e.e_c));
        chk("overflow", 32'(overflow), 32'(e.e_o));
        chk("commit", 32'(commit), 32'(e.e_cm));
        chk("exc_req", 32'(exc_req), 32'(e.e_req));
        chk("exc_pc", exc_pc, e.e_pc);
        chk("exc_lost", 32'(exc_lost), 32'(e.e_lost));
        chk("ovf_count", 32'(ovf_count), 32'(exp_cnt(e.e_cnt)));
    endtask

    task automatic drive(input vec_t e);
        in_valid    = e.v;
        a           = e.a;
        b           = e.b;
        sub         = e.sub;
        signed_mode = e.sm;
        pc          = e.pc;
        exc_ack     = e.ack;
        clr_stats   = e.clr;
    endtask

    task automatic apply(input vec_t e);
        drive(e);
        @(posedge clk);
        #1;
        n_vec++;
        chk_all(e);
    endtask

    vec_t idle_v, zero_v, post_v;

    initial begin
        // v a b sub sm pc ack clr | rv res c o cm req epc lost cnt
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                     0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0};
        vecs[1]  = '{1, 32'h7FFFFFFF, 32'h1, 0, 1, 32'h00400010, 0, 0,
                     1, 32'h80000000, 0, 1, 0, 1, 32'h00400010, 0, 1};
        vecs[2]  = '{1, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h0, 1, 0,
                     1, 32'h00000000, 1, 0, 1, 0, 32'h00400010, 0, 1};
        vecs[3]  = '{1, 32'h80000000, 32'h1, 1, 1, 32'h200, 0, 0,
                     1, 32'h7FFFFFFF, 0, 1, 0, 1, 32'h200, 0, 2};
        vecs[4]  = '{1, 32'h0, 32'h1, 1, 0, 32'h0, 1, 0,
                     1, 32'hFFFFFFFF, 1, 0, 1, 0, 32'h200, 0, 2};
        vecs[5]  = '{0, 32'h5, 32'h5, 0, 1, 32'h0, 0, 0,
                     0, 32'hFFFFFFFF, 1, 0, 0, 0, 32'h200, 0, 2};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 1,
                     0, 32'hFFFFFFFF, 1, 0, 0, 0, 32'h200, 0, 0};
        vecs[7]  = '{1, 32'h7FFFFFFF, 32'h1, 0, 1, 32'h100, 0, 0,
                     1, 32'h80000000, 0, 1, 0, 1, 32'h100, 0, 1};
        vecs[8]  = '{1, 32'h7FFFFFFF, 32'h1, 0, 1, 32'h104, 0, 0,
                     1, 32'h80000000, 0, 1, 0, 1, 32'h100, 1, 2};
        vecs[9]  = '{1, 32'h7FFFFFFF, 32'h1, 0, 1, 32'h108, 1, 0,
                     1, 32'h80000000, 0, 1, 0, 1, 32'h108, 1, 3};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 0,
                     0, 32'h80000000, 0, 1, 0, 0, 32'h108, 1, 3};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 1, 0,
                     0, 32'h80000000, 0, 1, 0, 0, 32'h108, 1, 3};
        vecs[12] = '{1, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h300, 0, 0,
                     1, 32'h80000000, 0, 1, 1, 0, 32'h108, 1, 3};
        vecs[13] = '{1, 32'h7FFFFFFF, 32'h1, 0, 1, 32'h400, 0, 0,
                     1, 32'h80000000, 0, 1, 0, 1, 32'h400, 1, 3};
        vecs[14] = '{1, 32'h7FFFFFFF, 32'h1, 0, 1, 32'h404, 0, 0,
                     1, 32'h80000000, 0, 1, 0, 1, 32'h400, 1, 3};
        vecs[15] = '{1, 32'h7FFFFFFF, 32'h1, 0, 1, 32'h408, 0, 1,
                     1, 32'h80000000, 0, 1, 0, 1, 32'h400, 0, 1};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 1, 0,
                     0, 32'h80000000, 0, 1, 0, 0, 32'h400, 0, 1};
        vecs[17] = '{1, 32'hFFFFFFFF, 32'h1, 0, 1, 32'h500, 0, 0,
                     1, 32'h00000000, 1, 0, 1, 0, 32'h400, 0, 1};
        vecs[18] = '{1, 32'h80000000, 32'h80000000, 0, 1, 32'h600, 0, 0,
                     1, 32'h00000000, 1, 1, 0, 1, 32'h600, 0, 2};

        idle_v = vecs[0];
        zero_v = vecs[0];
        drive(idle_v);
        reset = 1'b1;
        #12;
        n_vec++;
        cur = -1;
        chk_all(zero_v);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            cur = i;
            apply(vecs[i]);
        end

        // Async reset mid-cycle while an exception is pending.
        cur = 100;
        #3;
        reset = 1'b1;
        #1;
        n_vec++;
        zero_v.e_res = 32'h0;
        chk_all(zero_v);
        drive(idle_v);
        #2;
        reset = 1'b0;

        post_v = '{1, 32'h7FFFFFFF, 32'h1, 0, 1, 32'h700, 0, 0,
                   1, 32'h80000000, 0, 1, 0, 1, 32'h700, 0, 1};
        cur = 101;
        apply(post_v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
